// File: rtl/varredura_display_pkg.sv
// rtl/varredura_display_pkg.sv - shared constants and types for the 7-segment scan driver
package pkg_display;

   // Active-high segment patterns, bit 0 = a ... bit 6 = g
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_APAGADO = 7'h00;

   localparam logic [3:0] ANODO_APAGADO = 4'b1111;

   localparam int IDX_W = 2;
   typedef logic [IDX_W-1:0] idx_t;

   typedef struct packed {
      logic [15:0] dig;
      logic [3:0]  pt;
   } buf_t;

   localparam buf_t BUF_VAZIO = '{dig: 16'hFFFF, pt: 4'h0};

   function automatic logic [3:0] anodo_ativo(input idx_t idx);
      logic [3:0] a;
      a = ANODO_APAGADO;
      a[idx] = 1'b0;
      return a;
   endfunction

endpackage

// File: rtl/varredura_display_decod_bcd7.sv
// rtl/varredura_display_decod_bcd7.sv - combinational BCD to active-high 7-segment decoder
module decod_bcd7
   import pkg_display::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_APAGADO;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_APAGADO;
      endcase
   end

endmodule

// File: rtl/varredura_display.sv
// rtl/varredura_display.sv - 4-digit multiplexed 7-segment scanner with double buffer and blanking
module varredura_display
   import pkg_display::*;
#(
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        habilita,
   input  logic [15:0] digitos,
   input  logic [3:0]  pontos,
   input  logic        carregar,
   output logic        pendente,
   output logic [3:0]  anodo,
   output logic [6:0]  segmentos,
   output logic        ponto,
   output logic        fim_quadro
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [CW-1:0] count;
   idx_t          idx;
   buf_t          pend;
   buf_t          disp;
   buf_t          entrada;
   logic          tick;
   logic          fronteira;
   logic          em_branco;
   logic [3:0]    dig_atual;
   logic [6:0]    seg_ativo;

   assign entrada   = '{dig: digitos, pt: pontos};
   assign tick      = (count == CW'(PRESCALE - 1));
   assign fronteira = tick && (idx == idx_t'(3));
   assign dig_atual = disp.dig[{idx, 2'b00} +: 4];

   generate
      if (BLANK == 0) begin : g_sem_branco
         assign em_branco = 1'b0;
      end else begin : g_com_branco
         assign em_branco = (count < CW'(BLANK));
      end
   endgenerate

   decod_bcd7 u_decod (
      .bcd (dig_atual),
      .seg (seg_ativo)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         count      <= '0;
         idx        <= '0;
         pendente   <= 1'b0;
         pend       <= BUF_VAZIO;
         disp       <= BUF_VAZIO;
         anodo      <= ANODO_APAGADO;
         segmentos  <= ~SEG_APAGADO;
         ponto      <= 1'b1;
         fim_quadro <= 1'b0;
      end else if (!habilita) begin
         count      <= '0;
         idx        <= '0;
         anodo      <= ANODO_APAGADO;
         segmentos  <= ~SEG_APAGADO;
         ponto      <= 1'b1;
         fim_quadro <= 1'b0;
         // Dark display: no frame to protect, so pending data moves over right away
         if (pendente)
            disp <= pend;
         if (carregar) begin
            pend     <= entrada;
            pendente <= 1'b1;
         end else begin
            pendente <= 1'b0;
         end
      end else begin
         count      <= tick ? '0 : count + CW'(1);
         if (tick)
            idx <= idx + idx_t'(1);
         fim_quadro <= fronteira;

         // Display buffer only changes at the frame boundary; a coincident load bypasses pending
         if (fronteira) begin
            if (carregar) begin
               disp <= entrada;
               pend <= entrada;
            end else if (pendente) begin
               disp <= pend;
            end
            pendente <= 1'b0;
         end else if (carregar) begin
            pend     <= entrada;
            pendente <= 1'b1;
         end

         if (em_branco) begin
            anodo     <= ANODO_APAGADO;
            segmentos <= ~SEG_APAGADO;
            ponto     <= 1'b1;
         end else begin
            anodo     <= anodo_ativo(idx);
            segmentos <= ~seg_ativo;
            ponto     <= ~disp.pt[idx];
         end
      end
   end

endmodule

// File: tb/tb_varredura_display.sv
// tb/tb_varredura_display.sv - directed self-checking bench for varredura_display
module tb_varredura_display;

   logic        clk = 1'b0;
   logic        rst;
   logic        habilita;
   logic [15:0] digitos;
   logic [3:0]  pontos;
   logic        carregar;
   logic        pendente;
   logic [3:0]  anodo;
   logic [6:0]  segmentos;
   logic        ponto;
   logic        fim_quadro;

   int total = 0;
   int bad   = 0;
   int cur_t = 0;
   logic [3:0] prev_anodo = 4'b1111;

   typedef struct {
      int         t;
      logic [3:0] an;
      logic [6:0] sg;
      logic       pt;
      logic       fq;
   } vec_t;

   vec_t tab[12];

   always #5 clk = ~clk;

   varredura_display #(.PRESCALE(8), .BLANK(2)) dut (
      .CLK        (clk),
      .RST        (rst),
      .habilita   (habilita),
      .digitos    (digitos),
      .pontos     (pontos),
      .carregar   (carregar),
      .pendente   (pendente),
      .anodo      (anodo),
      .segmentos  (segmentos),
      .ponto      (ponto),
      .fim_quadro (fim_quadro)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (t=%0d): got %h want %h", nm, cur_t, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cur_t++;
      chk("one_hot_anodo", 32'($countones(~anodo) <= 1), 32'd1);
      chk("blank_gap", 32'(!(prev_anodo != 4'b1111 && anodo != 4'b1111 && prev_anodo != anodo)), 32'd1);
      prev_anodo = anodo;
   endtask

   task automatic advance_to(input int t);
      while (cur_t < t) step();
   endtask

   task automatic chk_out(input string nm, input logic [3:0] an, input logic [6:0] sg, input logic pt);
      chk({nm, "_anodo"}, 32'(anodo), 32'(an));
      chk({nm, "_seg"}, 32'(segmentos), 32'(sg));
      chk({nm, "_ponto"}, 32'(ponto), 32'(pt));
   endtask

   initial begin
      tab[0]  = '{1,  4'b1111, 7'h7F, 1'b1, 1'b0};
      tab[1]  = '{2,  4'b1111, 7'h7F, 1'b1, 1'b0};
      tab[2]  = '{3,  4'b1110, 7'h79, 1'b1, 1'b0};
      tab[3]  = '{8,  4'b1110, 7'h79, 1'b1, 1'b0};
      tab[4]  = '{9,  4'b1111, 7'h7F, 1'b1, 1'b0};
      tab[5]  = '{11, 4'b1101, 7'h24, 1'b0, 1'b0};
      tab[6]  = '{19, 4'b1011, 7'h30, 1'b1, 1'b0};
      tab[7]  = '{27, 4'b0111, 7'h19, 1'b1, 1'b0};
      tab[8]  = '{32, 4'b0111, 7'h19, 1'b1, 1'b1};
      tab[9]  = '{33, 4'b1111, 7'h7F, 1'b1, 1'b0};
      tab[10] = '{35, 4'b1110, 7'h79, 1'b1, 1'b0};
      tab[11] = '{64, 4'b0111, 7'h19, 1'b1, 1'b1};

      rst = 1'b1; habilita = 1'b0; carregar = 1'b0; digitos = 16'h0; pontos = 4'h0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk_out("reset", 4'b1111, 7'h7F, 1'b1);
      chk("reset_pendente", 32'(pendente), 32'd0);
      chk("reset_fim", 32'(fim_quadro), 32'd0);

      // Load while dark: pending, then straight to display on the next cycle
      carregar = 1'b1; digitos = 16'h4321; pontos = 4'b0010;
      step();
      carregar = 1'b0;
      chk("dark_load_pend", 32'(pendente), 32'd1);
      step();
      chk("dark_xfer_pend", 32'(pendente), 32'd0);

      habilita = 1'b1;
      cur_t = 0;
      // tab[11] lies past the double-buffer load below; run tab[0..10] first
      for (int i = 0; i < 11; i++) begin
         advance_to(tab[i].t);
         chk_out($sformatf("scan%0d", i), tab[i].an, tab[i].sg, tab[i].pt);
         chk($sformatf("scan%0d_fim", i), 32'(fim_quadro), 32'(tab[i].fq));
      end

      // Mid-frame load of 5555: display held until the boundary
      carregar = 1'b1; digitos = 16'h5555; pontos = 4'b0000;
      step();
      carregar = 1'b0;
      chk("db_pend_set", 32'(pendente), 32'd1);
      advance_to(43);
      chk_out("db_hold1", 4'b1101, 7'h24, 1'b0);
      advance_to(59);
      chk_out("db_hold3", 4'b0111, 7'h19, 1'b1);
      advance_to(63);
      chk("db_pend_before", 32'(pendente), 32'd1);
      advance_to(tab[11].t);
      chk_out("scan11", tab[11].an, tab[11].sg, tab[11].pt);
      chk("scan11_fim", 32'(fim_quadro), 32'(tab[11].fq));
      chk("db_pend_clear", 32'(pendente), 32'd0);
      advance_to(67);
      chk_out("db_new0", 4'b1110, 7'h12, 1'b1);
      advance_to(75);
      chk_out("db_new1", 4'b1101, 7'h12, 1'b1);

      // Load coincident with the boundary cycle (count 7, index 3 between edges 95 and 96)
      advance_to(95);
      carregar = 1'b1; digitos = 16'h9876; pontos = 4'b0000;
      step();
      carregar = 1'b0;
      chk("co_pend", 32'(pendente), 32'd0);
      chk("co_fim", 32'(fim_quadro), 32'd1);
      advance_to(99);
      chk_out("co_d0", 4'b1110, 7'h02, 1'b1);
      advance_to(107);
      chk_out("co_d1", 4'b1101, 7'h78, 1'b1);
      advance_to(115);
      chk_out("co_d2", 4'b1011, 7'h00, 1'b1);
      advance_to(123);
      chk_out("co_d3", 4'b0111, 7'h10, 1'b1);
      chk("co_pend_late", 32'(pendente), 32'd0);

      // Non-BCD values blank the segments but keep the anode and point
      advance_to(124);
      carregar = 1'b1; digitos = 16'hFEDA; pontos = 4'b0001;
      step();
      carregar = 1'b0;
      chk("hex_pend", 32'(pendente), 32'd1);
      advance_to(128);
      chk("hex_pend_clear", 32'(pendente), 32'd0);
      advance_to(131);
      chk_out("hex_d0", 4'b1110, 7'h7F, 1'b0);
      advance_to(147);
      chk_out("hex_d2", 4'b1011, 7'h7F, 1'b1);

      // Drop habilita mid slot 2, then re-enable
      habilita = 1'b0;
      step();
      chk_out("off_dark", 4'b1111, 7'h7F, 1'b1);
      chk("off_fim", 32'(fim_quadro), 32'd0);
      step();
      habilita = 1'b1;
      step();
      chk("re_blank0", 32'(anodo), 32'(4'b1111));
      step();
      chk("re_blank1", 32'(anodo), 32'(4'b1111));
      step();
      chk_out("re_slot0", 4'b1110, 7'h7F, 1'b0);

      // Reset in the middle of a load discards it
      rst = 1'b1; carregar = 1'b1; digitos = 16'h1234; pontos = 4'b1111;
      step();
      carregar = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk_out("rst2_dark0", 4'b1111, 7'h7F, 1'b1);
      chk("rst2_pend", 32'(pendente), 32'd0);
      step();
      step();
      chk_out("rst2_slot0", 4'b1110, 7'h7F, 1'b1);
      chk("rst2_pend_late", 32'(pendente), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/varredura_display.md
Name: varredura_display

Overview:
- 4-digit multiplexed 7-segment scan driver for the machine's front-panel display.
- Latches four BCD digits plus decimal points through a double buffer.
- Time-slices the digits onto shared segment lines with one-hot, active-low anode enables.
- Inserts a blanking gap at every digit switch to suppress ghosting.
- Consumes digit values from the panel control logic and drives the display pins directly.

Parameters:
PRESCALE, 50000, clock cycles per digit slot; legal range PRESCALE >= BLANK+2.
BLANK, 4, cycles at the start of each slot with all anodes off; 0 disables blanking.

Ports:
CLK  input  1  system clock, all logic on the rising edge
RST  input  1  synchronous reset, active-high
habilita  input  1  1 = scanning; 0 = display dark
digitos  input  16  BCD digits; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
pontos  input  4  decimal point per digit, 1 = lit
carregar  input  1  one-cycle strobe that captures digitos and pontos
pendente  output  1  1 = captured value not yet shown
anodo  output  4  active-low one-hot digit enable; bit i = digit i
segmentos  output  7  active-low segments; [0]=a ... [6]=g
ponto  output  1  active-low decimal point
fim_quadro  output  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset, synchronous on RST=1, overriding all else:
  - anodo=4'b1111, segmentos=7'h7F, ponto=1, fim_quadro=0, pendente=0.
  - Prescaler=0, digit index=0.
  - Pending and display buffers = all digits 4'hF (blank), points 0.
  - Reset mid-slot or mid-load discards the pending data.
- Prescaler counts 0..PRESCALE-1 while habilita=1. tick = (count==PRESCALE-1). Count wraps to 0 after tick.
- Digit index, 2 bits, increments on tick and wraps 3->0. Frame boundary = tick while index==3.
- Slot phase:
  - count < BLANK: all anodes off (anodo=4'b1111, segmentos=7'h7F, ponto=1).
  - Otherwise: anodo drives a low on bit index only; segmentos = decode(display digit[index]); ponto = ~display point[index].
- All outputs are registered. Each output reflects the count/index of the previous cycle, so latency = 1 cycle.
- BCD decode, active-high pattern before inversion:
  - Values 0..9 use the standard patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Values 10..15 blank (all segments off).
- Double buffer:
  - carregar=1 copies digitos/pontos into the pending buffer and sets pendente=1.
  - Repeated loads before a boundary: last one wins.
  - At a frame boundary with pendente=1, the pending buffer copies to the display buffer and pendente clears.
  - The display buffer never changes mid-frame.
  - carregar in the same cycle as a frame boundary: the incoming value goes straight into the display buffer, pendente=0 on the next cycle.
- fim_quadro = 1 for exactly one cycle, the cycle after each frame boundary.
- habilita=0:
  - Prescaler and index forced to 0.
  - Outputs at the dark values (as at reset); fim_quadro=0.
  - carregar is still accepted into the pending buffer. Pending data transfers to the display buffer immediately on the next cycle while disabled, so that re-enable shows current data.
- habilita rising: scanning starts at slot 0 with count 0, so the BLANK gap applies first.

Decomposition:
- Package pkg_display:
  - 7-bit segment constants for 0..9 and SEG_APAGADO.
  - ANODO_APAGADO = 4'b1111.
  - Index width constant = 2.
- Sub-module decod_bcd7: combinational BCD-to-segment decoder, 4-bit in, 7-bit active-high out. The scanner inverts and registers the result.

Test Plan:
- Reset, PRESCALE=8, BLANK=2: hold RST 3 cycles -> anodo=1111, segmentos=7F, ponto=1, pendente=0 on the cycle after RST falls with habilita=0.
- Scan order: load 16'h4321, pontos=4'b0010, habilita=1 ->
  - Slot 0 from count 2: anodo=1110, segmentos=~06=79.
  - Slot 1: anodo=1101, seg=~5B=24, ponto=0.
  - Slots 2 and 3 follow; fim_quadro pulses every 32 cycles.
- Blanking: sample the first 2 cycles of each slot -> anodo=1111. Never two anodes low, never a digit-to-digit change without the gap.
- Double buffer: load 16'h5555 mid-frame -> pendente=1, display unchanged until the boundary. Next frame shows 5s on all digits; pendente=0 one cycle after the boundary.
- Coincident load: carregar on the boundary cycle with 16'h9876 -> pendente stays 0, next frame shows 6,7,8,9. Values A..F -> segmentos=7F during active phase.
- habilita drop mid-slot 2 -> dark on the next cycle. Re-enable -> resumes at slot 0 with 2 blank cycles.
